ofmap_drain: RTL and testbench
==============================

OFMAP_DRAIN -- requirements
Module: ofmap_drain

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, sample width; ADDR_WIDTH, default 16, counter/config width; DEPTH, default 4096, internal buffer words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; latches configuration when in IDLE.
REQ-005 chans_per_mem  input  ADDR_WIDTH  channels per output pixel.
REQ-006 o_dimension  input  ADDR_WIDTH  output feature-map side (square map).
REQ-007 valid_in  input  1  input beat valid.
REQ-008 data_in  input  DATA_WIDTH  result sample, pixel-major order: pixel outer (raster), channel inner.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 data_out  output  DATA_WIDTH  drained sample, channel-major order: channel outer, pixel inner (raster).
REQ-011 out_valid  output  1  data_out valid.
REQ-012 out_ready  input  1  downstream accepts data_out.
REQ-013 last_out  output  1  high with the final drained beat.
REQ-014 ram_full  output  1  high from fill completion until drain completion.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 cfg_err  output  1  one-cycle pulse on rejected configuration.

Function
REQ-017 States SHALL be IDLE, FILL, DRAIN, DONE.
REQ-018 On start in IDLE: TOTAL = o_dimension*o_dimension*chans_per_mem, computed at 2*ADDR_WIDTH bits and latched along with chans_per_mem and o_dimension.
- Valid configuration: next state FILL.
- TOTAL==0 or TOTAL>DEPTH: pulse cfg_err next cycle and stay in IDLE.
REQ-019 start outside IDLE SHALL be ignored; configuration inputs are sampled only at the accepted start.
REQ-020 In FILL, in_ready=1. A beat is accepted when valid_in&in_ready. Accepted beat k (0-based) is written to buffer address k.
REQ-021 When the TOTAL-th beat is accepted: the next state is DRAIN, in_ready drops the following cycle, and ram_full rises the same cycle.
REQ-022 In all states other than FILL, in_ready=0. valid_in outside FILL is ignored and no write occurs.
REQ-023 The DRAIN read order is nested counters ch (outer, 0..chans-1) and pix (inner, 0..o_dim^2-1), with read address = pix*chans_per_mem + ch. pix wraps to 0 and ch increments when pix==o_dim^2-1.
REQ-024 The buffer is a synchronous-read RAM with 1-cycle latency. The block prefetches so that out_valid first rises exactly 2 cycles after entering DRAIN.
REQ-025 Once out_valid=1, data_out and last_out SHALL hold stable until out_valid&out_ready.
REQ-026 With out_ready held high, the block SHALL sustain one beat per cycle with no bubbles. No beat is lost or duplicated under arbitrary out_ready stalls.
REQ-027 last_out=1 only on beat TOTAL-1 (ch=chans-1, pix=o_dim^2-1).
REQ-028 On acceptance of the last beat, the next state is DONE and out_valid drops the following cycle.
REQ-029 DONE lasts one cycle, clears ram_full, then goes to IDLE. A new start is accepted from IDLE thereafter.
REQ-030 Address arithmetic SHALL use ADDR_WIDTH-bit counters; no counter exceeds TOTAL-1, guaranteed by REQ-018.
REQ-031 If valid_in and out_ready are asserted simultaneously, behaviour SHALL be decided by state only; fill and drain never overlap.

Reset
REQ-032 While rst=0: state=IDLE, and in_ready, out_valid, last_out, ram_full, busy and cfg_err are all 0. Counters and latched config are cleared; data_out=0.
REQ-033 Reset asserted mid-FILL or mid-DRAIN SHALL abort immediately; no further writes or outputs occur.
- Buffer contents are not cleared.
- After deassertion the block waits in IDLE for start.

Verification
REQ-034 chans=2, o_dim=2, data_in 0..7 streamed with valid_in constant, out_ready=1 -> data_out 0,2,4,6,1,3,5,7; last_out with 7; in_ready low after 8 beats.
REQ-035 Same config, out_ready toggling 1,0,1,0 and random valid_in gaps -> identical output sequence; data_out held stable during stalls; no drops.
REQ-036 chans=64, o_dim=2 (TOTAL=256), data_in=k -> output beat n = (n%4)*64 + n/4; last_out on beat 255 only; ram_full high over the drain.
REQ-037 start with o_dim=0 -> cfg_err pulse, busy stays 0. start with chans=1024, o_dim=3 (9216>4096) -> cfg_err, busy stays 0.
REQ-038 rst=0 after 5 of 8 FILL beats, then reconfigure chans=1, o_dim=2 with data 10..13 -> output 10,11,12,13, last_out with 13.
REQ-039 start pulsed during DRAIN with a different config -> ignored; the current drain completes unchanged.

Source files
------------

// File: rtl/ofmap_drain_if.sv
// rtl/ofmap_drain_if.sv - sample streams into and out of the ofmap drain buffer
interface ofmap_drain_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  last_out;

    modport slave (
        input  valid_in, data_in, out_ready,
        output in_ready, data_out, out_valid, last_out
    );

    modport master (
        output valid_in, data_in, out_ready,
        input  in_ready, data_out, out_valid, last_out
    );
endinterface

// File: rtl/ofmap_drain.sv
// rtl/ofmap_drain.sv - buffers a pixel-major output feature map and drains it channel-major
module ofmap_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] chans_per_mem,
    input  logic [ADDR_WIDTH-1:0] o_dimension,
    ofmap_drain_if.slave          bus,
    output logic                  ram_full,
    output logic                  busy,
    output logic                  cfg_err
);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW     = 2 * ADDR_WIDTH;
    localparam logic [WW-1:0] DEPTH_W = WW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   stride;
    logic [ADDR_WIDTH-1:0]   chans_m1;
    logic [ADDR_WIDTH-1:0]   npix_m1;
    logic [ADDR_WIDTH-1:0]   tot_m1;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH-1:0]   ch;
    logic [ADDR_WIDTH-1:0]   pix;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_pend;
    logic                    in_rdy;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   ram_q;
    logic                    ram_v;
    logic                    ram_last;

    logic [DATA_WIDTH-1:0]   sk_data;
    logic                    sk_valid;
    logic                    sk_last;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_vld;
    logic                    out_last;

    logic [WW-1:0]           pix_w;
    logic [WW-1:0]           total_w;
    logic                    cfg_ok;
    logic                    wr_en;
    logic                    rd_en;
    logic                    rd_last;
    logic                    pop;
    logic [1:0]              occ;

    assign bus.in_ready  = in_rdy;
    assign bus.data_out  = out_data;
    assign bus.out_valid = out_vld;
    assign bus.last_out  = out_last;

    // The pixel count is bounded separately so the 2*ADDR_WIDTH product cannot wrap into range.
    assign pix_w   = {{ADDR_WIDTH{1'b0}}, o_dimension} * {{ADDR_WIDTH{1'b0}}, o_dimension};
    assign total_w = pix_w * {{ADDR_WIDTH{1'b0}}, chans_per_mem};
    assign cfg_ok  = (total_w != '0) && (total_w <= DEPTH_W) && (pix_w <= DEPTH_W);

    assign wr_en   = (state == FILL) && bus.valid_in && in_rdy;
    assign pop     = out_vld && bus.out_ready;
    assign occ     = 2'(out_vld) + 2'(sk_valid) + 2'(ram_v);
    assign rd_last = (ch == chans_m1) && (pix == npix_m1);
    // Items in flight plus items held never exceed the two output slots.
    assign rd_en   = (state == DRAIN) && rd_pend && ((occ < 2'd2) || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[MEM_AW-1:0]] <= bus.data_in;
        end
        if (rd_en) begin
            ram_q <= mem[rd_addr[MEM_AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            stride   <= '0;
            chans_m1 <= '0;
            npix_m1  <= '0;
            tot_m1   <= '0;
            wr_addr  <= '0;
            ch       <= '0;
            pix      <= '0;
            rd_addr  <= '0;
            rd_pend  <= 1'b0;
            in_rdy   <= 1'b0;
            ram_v    <= 1'b0;
            ram_last <= 1'b0;
            sk_data  <= '0;
            sk_valid <= 1'b0;
            sk_last  <= 1'b0;
            out_data <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            ram_full <= 1'b0;
            busy     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            stride   <= chans_per_mem;
                            chans_m1 <= chans_per_mem - ADDR_WIDTH'(1);
                            npix_m1  <= pix_w[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                            tot_m1   <= total_w[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
                            wr_addr  <= '0;
                            in_rdy   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= FILL;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        wr_addr <= wr_addr + ADDR_WIDTH'(1);
                        if (wr_addr == tot_m1) begin
                            in_rdy   <= 1'b0;
                            ram_full <= 1'b1;
                            ch       <= '0;
                            pix      <= '0;
                            rd_addr  <= '0;
                            rd_pend  <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_en) begin
                        if (rd_last) begin
                            rd_pend <= 1'b0;
                        end else if (pix == npix_m1) begin
                            pix     <= '0;
                            ch      <= ch + ADDR_WIDTH'(1);
                            rd_addr <= ch + ADDR_WIDTH'(1);
                        end else begin
                            pix     <= pix + ADDR_WIDTH'(1);
                            rd_addr <= rd_addr + stride;
                        end
                    end
                    if (pop && out_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    ram_full <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            ram_v    <= rd_en;
            ram_last <= rd_en && rd_last;

            // Skid slot holds the older beat whenever the output register is stalled.
            if (!out_vld || pop) begin
                if (sk_valid) begin
                    out_data <= sk_data;
                    out_last <= sk_last;
                    out_vld  <= 1'b1;
                    sk_valid <= ram_v;
                    sk_data  <= ram_q;
                    sk_last  <= ram_last;
                end else if (ram_v) begin
                    out_data <= ram_q;
                    out_last <= ram_last;
                    out_vld  <= 1'b1;
                end else begin
                    out_vld  <= 1'b0;
                    out_last <= 1'b0;
                end
            end else if (ram_v) begin
                sk_valid <= 1'b1;
                sk_data  <= ram_q;
                sk_last  <= ram_last;
            end
        end
    end
endmodule

// File: tb/tb_ofmap_drain.sv
// tb/tb_ofmap_drain.sv - self-checking bench for ofmap_drain
module tb_ofmap_drain;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] chans_per_mem = '0;
    logic [AW-1:0] o_dimension = '0;
    logic          ram_full;
    logic          busy;
    logic          cfg_err;

    ofmap_drain_if #(.DATA_WIDTH(DW)) bus ();

    ofmap_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .chans_per_mem(chans_per_mem),
        .o_dimension  (o_dimension),
        .bus          (bus.slave),
        .ram_full     (ram_full),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int chans;
        int odim;
        int mode;     // 0: out_ready high, 1: toggling, 2: random
        int gap;      // percent chance of a valid_in gap
        bit seq;      // data_in = base + k instead of random
        bit exp_err;  // expected cfg_err / rejection
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_case(input int chans, input int odim, input bit exp_err, input int mode,
                           input int gap, input bit seq, input int base, input bit poke);
        int total;
        int npix;
        int sent;
        int got;
        int cyc;
        int budget;
        int drain_cyc;
        int first_valid;
        int bubbles;
        int hold_bad;
        int rdy_bad;
        int full_bad;
        bit held;
        bit poked;
        logic [DW-1:0] hv;
        logic          hl;
        logic [DW-1:0] src[$];
        logic [DW-1:0] exp_q[$];

        total = chans * odim * odim;
        npix  = odim * odim;

        @(negedge clk);
        start = 1'b1;
        chans_per_mem = AW'(chans);
        o_dimension = AW'(odim);
        @(negedge clk);
        start = 1'b0;
        check("cfg_err", cfg_err, 32'(exp_err));
        check("busy_after_start", busy, 32'(!exp_err));
        if (exp_err) begin
            @(negedge clk);
            check("cfg_err_one_cycle", cfg_err, 0);
            check("busy_stays_low", busy, 0);
            return;
        end
        check("in_ready_fill", bus.in_ready, 1);

        for (int k = 0; k < total; k++) src.push_back(seq ? DW'(base + k) : DW'($urandom));
        for (int c = 0; c < chans; c++)
            for (int p = 0; p < npix; p++)
                exp_q.push_back(src[p * chans + c]);

        sent = 0; got = 0; cyc = 0; budget = 10 * total + 200;
        drain_cyc = -1; first_valid = -1; bubbles = 0; hold_bad = 0;
        rdy_bad = 0; full_bad = 0; held = 0; poked = 0; hv = '0; hl = 0;
        while (got < total && cyc < budget) begin
            if (held && (!bus.out_valid || bus.data_out !== hv || bus.last_out !== hl)) hold_bad++;
            if (sent == total) begin
                if (bus.in_ready !== 1'b0) rdy_bad++;
                if (ram_full !== 1'b1) full_bad++;
                if (drain_cyc < 0) drain_cyc = cyc;
                if (poke && !poked) begin
                    start = 1'b1; chans_per_mem = AW'(1); o_dimension = AW'(1); poked = 1;
                end else begin
                    start = 1'b0;
                end
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (mode == 0 && first_valid >= 0 && !bus.out_valid) bubbles++;

            bus.valid_in = (sent == total) ? 1'b1 : ($urandom_range(99) >= 32'(gap));
            bus.data_in  = (sent < total) ? src[sent] : 16'hdead;
            if (bus.in_ready && bus.valid_in && sent < total) sent++;

            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = (cyc % 2 == 0);
                default: bus.out_ready = 1'($urandom_range(1));
            endcase
            if (bus.out_valid && bus.out_ready) begin
                check("data_out", bus.data_out, exp_q[got]);
                check("last_out", bus.last_out, 32'(got == total - 1));
                got++;
            end
            held = bus.out_valid && !bus.out_ready;
            hv = bus.data_out;
            hl = bus.last_out;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        bus.valid_in = 1'b0;
        bus.out_ready = 1'b0;
        check("beats_drained", got, total);
        check("hold_stable_violations", hold_bad, 0);
        check("in_ready_after_fill", rdy_bad, 0);
        check("ram_full_over_drain", full_bad, 0);
        if (mode == 0 && gap == 0) begin
            check("first_valid_latency", first_valid - drain_cyc, 2);
            check("bubbles", bubbles, 0);
        end
        check("out_valid_after_last", bus.out_valid, 0);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("ram_full_after_done", ram_full, 0);
    endtask

    initial begin
        vec_t vecs[$];
        int c;
        int o;
        int t;

        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_last_out", bus.last_out, 0);
        check("rst_ram_full", ram_full, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_data_out", bus.data_out, 0);
        rst = 1'b1;
        @(negedge clk);

        // chans, odim, mode, gap, seq, exp_err
        vecs.push_back('{2, 2, 0, 0, 1, 0});
        vecs.push_back('{2, 2, 1, 30, 1, 0});
        vecs.push_back('{64, 2, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 1});
        vecs.push_back('{1024, 3, 0, 0, 0, 1});
        vecs.push_back('{0, 5, 0, 0, 0, 1});
        vecs.push_back('{4097, 1, 0, 0, 0, 1});
        vecs.push_back('{1, 1, 2, 50, 0, 0});
        vecs.push_back('{3, 5, 2, 40, 0, 0});
        vecs.push_back('{4, 4, 0, 0, 0, 0});
        vecs.push_back('{1024, 2, 2, 20, 0, 0});
        foreach (vecs[i])
            do_case(vecs[i].chans, vecs[i].odim, vecs[i].exp_err, vecs[i].mode,
                    vecs[i].gap, vecs[i].seq, 0, 1'b0);

        // Reset part-way through a fill, then a fresh small map.
        @(negedge clk);
        start = 1'b1; chans_per_mem = AW'(2); o_dimension = AW'(2);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.valid_in = 1'b1; bus.data_in = DW'(100 + k);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_ram_full", ram_full, 0);
        check("abort_out_valid", bus.out_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_abort", busy, 0);
        do_case(1, 2, 1'b0, 0, 0, 1'b1, 10, 1'b0);

        // start pulsed during drain with another config must be ignored.
        do_case(2, 3, 1'b0, 2, 10, 1'b1, 40, 1'b1);
        @(negedge clk);
        check("poke_no_restart", busy, 0);

        for (int r = 0; r < 6; r++) begin
            c = $urandom_range(1, 20);
            o = $urandom_range(0, 9);
            t = c * o * o;
            do_case(c, o, (t == 0 || t > DEPTH), 2, $urandom_range(0, 60), 1'b0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
